// File: rtl/hub75_fb_pkg.sv
// Shared constants, FSM encoding and bus payload type for the HUB75 frame-buffer arbiter.
package hub75_fb_pkg;

  localparam int unsigned FB_ADDR_W = 13;
  localparam int unsigned FB_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] wdata;
    logic                 wren;
    logic                 rden;
  } fb_cmd_t;

  // $clog2 that never returns less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_fb_arbiter_if.sv
// Requester-side handshake, shared frame-buffer command bus and arbiter status.
interface hub75_fb_arbiter_if
  import hub75_fb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned LOG_N_REQ = clog2_min1(N_REQ)
) ();

  logic [N_REQ-1:0]           ctrl_req;
  logic [N_REQ-1:0]           ctrl_gnt;
  logic [N_REQ-1:0]           ctrl_rel;
  logic [N_REQ*FB_ADDR_W-1:0] req_addr;
  logic [N_REQ*FB_DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]           req_wren;
  logic [N_REQ-1:0]           req_rden;
  logic [FB_ADDR_W-1:0]       fb_addr;
  logic [FB_DATA_W-1:0]       fb_wdata;
  logic                       fb_wren;
  logic                       fb_rden;
  logic [LOG_N_REQ-1:0]       owner;
  logic                       busy;
  logic                       err_timeout;

  modport master (
    output ctrl_req, ctrl_rel, req_addr, req_wdata, req_wren, req_rden,
    input  ctrl_gnt, fb_addr, fb_wdata, fb_wren, fb_rden, owner, busy, err_timeout
  );

  modport slave (
    input  ctrl_req, ctrl_rel, req_addr, req_wdata, req_wren, req_rden,
    output ctrl_gnt, fb_addr, fb_wdata, fb_wren, fb_rden, owner, busy, err_timeout
  );

endinterface

// File: rtl/hub75_rr_pick.sv
// Round-robin picker: first requester at or after (last+1) mod N_REQ, wrapping.
module hub75_rr_pick
  import hub75_fb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned LOG_N_REQ = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0]     i_req,
  input  logic [LOG_N_REQ-1:0] i_last,
  output logic                 o_valid_c,
  output logic [LOG_N_REQ-1:0] o_winner_c
);

  int unsigned          w_base;
  logic [2*N_REQ-1:0]   w_dbl;
  logic [N_REQ-1:0]     w_rot;

  // Rotate so bit 0 is the highest-priority candidate, then take the first set bit.
  always_comb begin
    w_base     = (32'(i_last) + 32'd1) % N_REQ;
    w_dbl      = {i_req, i_req} >> w_base;
    w_rot      = w_dbl[N_REQ-1:0];
    o_valid_c  = 1'b0;
    o_winner_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!o_valid_c && w_rot[i]) begin
        o_valid_c  = 1'b1;
        o_winner_c = LOG_N_REQ'((w_base + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/hub75_fb_arbiter.sv
// Frame-buffer access arbiter: round-robin ownership with hold timeout and an owner-selected command mux.
module hub75_fb_arbiter
  import hub75_fb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_HOLD  = 1024,
  parameter int unsigned LOG_N_REQ = clog2_min1(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  hub75_fb_arbiter_if.slave bus
);

  localparam int unsigned       HOLD_W    = clog2_min1(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [LOG_N_REQ-1:0] r_owner;
  logic [HOLD_W-1:0]    r_hold;
  logic [N_REQ-1:0]     r_gnt;
  logic                 r_busy;
  logic                 r_err;

  logic                 w_pick_valid;
  logic [LOG_N_REQ-1:0] w_pick_idx;
  logic                 w_rel;
  logic                 w_timeout;
  logic                 w_set_err;
  fb_cmd_t              w_cmd;

  logic [FB_ADDR_W-1:0] w_addr  [N_REQ];
  logic [FB_DATA_W-1:0] w_wdata [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_addr[gi]  = bus.req_addr[gi*FB_ADDR_W +: FB_ADDR_W];
    assign w_wdata[gi] = bus.req_wdata[gi*FB_DATA_W +: FB_DATA_W];
  end

  hub75_rr_pick #(
    .N_REQ     (N_REQ),
    .LOG_N_REQ (LOG_N_REQ)
  ) u_pick (
    .i_req      (bus.ctrl_req),
    .i_last     (r_owner),
    .o_valid_c  (w_pick_valid),
    .o_winner_c (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state; a release coinciding with the timeout counts as a normal release.
  always_comb begin
    w_next    = r_state;
    w_rel     = 1'b0;
    w_timeout = 1'b0;
    w_set_err = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_pick_valid) w_next = ST_GRANT;
      ST_GRANT: w_next = ST_BUSY;
      ST_BUSY: begin
        w_rel     = bus.ctrl_rel[r_owner];
        w_timeout = (r_hold == HOLD_LAST);
        w_set_err = w_timeout && !w_rel;
        if (w_rel || w_timeout) w_next = ST_GAP;
      end
      ST_GAP:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= LOG_N_REQ'(N_REQ - 1);
      r_hold  <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_pick_valid) r_owner <= w_pick_idx;
      if (w_next == ST_GRANT)                         r_hold <= '0;
      else if (r_state == ST_BUSY && r_hold != '1)    r_hold <= r_hold + HOLD_W'(1);
      r_gnt  <= (w_next == ST_GRANT) ? (N_REQ'(1) << w_pick_idx) : '0;
      r_busy <= (w_next != ST_IDLE);
      if (w_set_err) r_err <= 1'b1;
    end
  end

  // Owner's command passes straight through while owned, including the GAP cycle.
  always_comb begin
    w_cmd = '0;
    if (r_state != ST_IDLE) begin
      w_cmd.addr  = w_addr[r_owner];
      w_cmd.wdata = w_wdata[r_owner];
      w_cmd.wren  = bus.req_wren[r_owner];
      w_cmd.rden  = bus.req_rden[r_owner];
    end
  end

  assign bus.fb_addr     = w_cmd.addr;
  assign bus.fb_wdata    = w_cmd.wdata;
  assign bus.fb_wren     = w_cmd.wren;
  assign bus.fb_rden     = w_cmd.rden;
  assign bus.ctrl_gnt    = r_gnt;
  assign bus.owner       = r_owner;
  assign bus.busy        = r_busy;
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Randomized bench for hub75_fb_arbiter against a round-robin ownership model.
module tb_hub75_fb_arbiter;
  import hub75_fb_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned MH = 16;
  localparam int unsigned LG = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hub75_fb_arbiter_if #(.N_REQ(N), .LOG_N_REQ(LG)) bus ();

  hub75_fb_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .LOG_N_REQ(LG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: last owner and sticky timeout flag; per-requester command currently driven.
  int              m_last;
  bit              m_err;
  logic [12:0]     a_addr [N];
  logic [15:0]     a_wd   [N];
  logic            a_wr   [N];
  logic            a_rd   [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (last + k) % int'(N);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < int'(N); i++) begin
      a_addr[i] = 13'($urandom);
      a_wd[i]   = 16'($urandom);
      a_wr[i]   = 1'($urandom);
      a_rd[i]   = 1'($urandom);
      bus.req_addr[i*13 +: 13]  = a_addr[i];
      bus.req_wdata[i*16 +: 16] = a_wd[i];
      bus.req_wren[i]           = a_wr[i];
      bus.req_rden[i]           = a_rd[i];
    end
  endtask

  task automatic check_idle(input string ph);
    check({ph, ".busy"},  32'(bus.busy),        32'd0);
    check({ph, ".gnt"},   32'(bus.ctrl_gnt),    32'd0);
    check({ph, ".wren"},  32'(bus.fb_wren),     32'd0);
    check({ph, ".rden"},  32'(bus.fb_rden),     32'd0);
    check({ph, ".addr"},  32'(bus.fb_addr),     32'd0);
    check({ph, ".wdata"}, 32'(bus.fb_wdata),    32'd0);
    check({ph, ".owner"}, 32'(bus.owner),       32'(m_last));
    check({ph, ".err"},   32'(bus.err_timeout), 32'(m_err));
  endtask

  task automatic check_owned(input string ph, input int win, input bit exp_gnt);
    check({ph, ".busy"},  32'(bus.busy),        32'd1);
    check({ph, ".gnt"},   32'(bus.ctrl_gnt),    exp_gnt ? (32'd1 << win) : 32'd0);
    check({ph, ".owner"}, 32'(bus.owner),       32'(win));
    check({ph, ".addr"},  32'(bus.fb_addr),     32'(a_addr[win]));
    check({ph, ".wdata"}, 32'(bus.fb_wdata),    32'(a_wd[win]));
    check({ph, ".wren"},  32'(bus.fb_wren),     32'(a_wr[win]));
    check({ph, ".rden"},  32'(bus.fb_rden),     32'(a_rd[win]));
    check({ph, ".err"},   32'(bus.err_timeout), 32'(m_err));
  endtask

  // One arbitration round starting in an IDLE cycle; owner releases after d BUSY cycles.
  task automatic run_round(input logic [N-1:0] req, input int d, input bit do_reset);
    int win;
    int leave;
    win   = rr_ref(req, m_last);
    leave = (d < int'(MH)) ? d : int'(MH);

    bus.ctrl_req = req;
    bus.ctrl_rel = N'($urandom);
    drive_data();
    #1 check_idle("idle");

    @(negedge clk);
    m_last       = win;
    bus.ctrl_req = N'($urandom);
    bus.ctrl_rel = N'($urandom);
    drive_data();
    #1 check_owned("grant", win, 1'b1);

    for (int k = 1; k <= leave; k++) begin
      @(negedge clk);
      bus.ctrl_req = N'($urandom);
      bus.ctrl_rel = (N'($urandom) & ~(N'(1) << win)) | ((k == d) ? (N'(1) << win) : N'(0));
      drive_data();
      #1 check_owned("busy", win, 1'b0);
      if (do_reset && k == 2) begin
        bus.req_wren = '1;
        rst_n        = 1'b0;
        m_last       = int'(N) - 1;
        m_err        = 1'b0;
        #1 check_idle("rst_mid");
        @(negedge clk);
        check_idle("rst_hold");
        rst_n        = 1'b1;
        bus.ctrl_req = '0;
        return;
      end
    end
    if (d > int'(MH)) m_err = 1'b1;

    @(negedge clk);
    bus.ctrl_req = N'($urandom);
    bus.ctrl_rel = N'($urandom);
    drive_data();
    #1 check_owned("gap", win, 1'b0);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ctrl_req = '0;
      bus.ctrl_rel = N'($urandom);
      drive_data();
      #1 check_idle("idle_wait");
      @(negedge clk);
    end
  endtask

  initial begin
    m_last        = int'(N) - 1;
    m_err         = 1'b0;
    bus.ctrl_req  = '0;
    bus.ctrl_rel  = '0;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.req_wren  = '1;
    bus.req_rden  = '1;
    for (int i = 0; i < int'(N); i++) begin
      a_addr[i] = '0; a_wd[i] = '0; a_wr[i] = 1'b0; a_rd[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    bus.req_wren = '0;
    bus.req_rden = '0;

    run_round(2'b01, 9, 1'b0);
    run_round(2'b11, 3, 1'b0);
    run_round(2'b11, 3, 1'b0);
    run_round(2'b11, 1, 1'b0);
    run_round(2'b10, int'(MH), 1'b0);
    run_round(2'b11, int'(MH) + 1, 1'b0);
    run_round(2'b11, 4, 1'b0);
    idle_cycles(2);

    for (int r = 0; r < 60; r++) begin
      run_round(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(1, MH + 6)), 1'b0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    run_round(2'b01, 10, 1'b1);
    run_round(2'b11, 3, 1'b0);
    run_round(2'b11, 2, 1'b0);
    idle_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hub75_fb_arbiter.md
HUB75_FB_ARBITER -- requirements
Module: hub75_fb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of frame-buffer requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 1024: maximum ownership length in cycles before a forced release.
REQ-003 SHALL have derived parameter LOG_N_REQ = max(1, $clog2(N_REQ)).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ctrl_req  input  N_REQ  per-requester access request (level).
REQ-007 SHALL have port ctrl_gnt  output  N_REQ  per-requester grant (one-cycle pulse).
REQ-008 SHALL have port ctrl_rel  input  N_REQ  per-requester release (one-cycle pulse).
REQ-009 SHALL have port req_addr  input  N_REQ*13  flattened requester addresses; slice i = [13*i+12:13*i].
REQ-010 SHALL have port req_wdata  input  N_REQ*16  flattened requester write data.
REQ-011 SHALL have port req_wren  input  N_REQ  per-requester write enable.
REQ-012 SHALL have port req_rden  input  N_REQ  per-requester read enable.
REQ-013 SHALL have port fb_addr  output  13  shared frame-buffer address.
REQ-014 SHALL have port fb_wdata  output  16  shared frame-buffer write data.
REQ-015 SHALL have port fb_wren  output  1  shared write enable.
REQ-016 SHALL have port fb_rden  output  1  shared read enable.
REQ-017 SHALL have port owner  output  LOG_N_REQ  index of the current or last owner.
REQ-018 SHALL have port busy  output  1  high while in GRANT, BUSY or GAP.
REQ-019 SHALL have port err_timeout  output  1  sticky flag set by a forced release.
REQ-020 The frame-buffer read data path SHALL NOT pass through this block; RAM read data is broadcast to all requesters.

Function
REQ-021 The FSM SHALL have four states: IDLE, GRANT, BUSY, GAP.
REQ-022 IDLE: if any ctrl_req bit is high, pick the winner round-robin, starting at index (owner+1) mod N_REQ; latch it into owner; go to GRANT. Otherwise stay in IDLE.
REQ-023 GRANT: ctrl_gnt[owner]=1 for exactly this one cycle; unconditional transition to BUSY.
REQ-024 BUSY: on ctrl_rel[owner]=1, or when the hold counter reaches MAX_HOLD-1, go to GAP.
REQ-025 GAP: one turnaround cycle; unconditional transition to IDLE.
REQ-026 Grant latency SHALL be 2 cycles from req sampled in IDLE to ctrl_gnt high; the minimum re-grant spacing is 1 cycle after GAP.
REQ-027 ctrl_req SHALL be ignored outside IDLE; a requester is expected to drop req the cycle after its gnt.
REQ-028 ctrl_rel from a non-owner, or in any state other than BUSY, SHALL be ignored.
REQ-029 The mux SHALL drive fb_* from the owner's slice in GRANT, BUSY and GAP, so trailing writes are honoured one cycle after rel.
REQ-030 In IDLE, fb_wren and fb_rden SHALL be 0 and fb_addr/fb_wdata SHALL hold 0.
REQ-031 fb_* outputs SHALL be combinational from the owner register and the inputs, with no added pipeline latency.
REQ-032 Hold counter: width $clog2(MAX_HOLD); cleared on entry to GRANT; increments in BUSY; saturates without wrapping.
REQ-033 A forced release SHALL set err_timeout; it clears only on reset. No rel is expected from the timed-out owner afterwards.
REQ-034 If rel and timeout coincide, the transition SHALL be a normal release; err_timeout SHALL NOT be set.
REQ-035 Round-robin SHALL wrap from N_REQ-1 to 0, and any requester SHALL be granted within N_REQ arbitration rounds.

Reset
REQ-036 On rst_n=0, asynchronously: state=IDLE, ctrl_gnt=0, owner=N_REQ-1 (requester 0 has first priority), hold counter=0, err_timeout=0, busy=0, fb_wren=0, fb_rden=0.
REQ-037 Reset mid-ownership SHALL abort with no gnt or write glitch; after release of reset, the block SHALL restart from IDLE.

Structure
REQ-038 The shared package hub75_fb_pkg SHALL hold FB_ADDR_W=13, FB_DATA_W=16 and the FSM state encoding.
REQ-039 The round-robin picker SHALL be a sub-module, hub75_rr_pick (inputs: req vector and last index; outputs: valid and winner index).

Verification
REQ-040 Reset, then req=2'b01 -> gnt[0] pulses at cycle 2; rel[0] at cycle 10 -> GAP at cycle 11, busy low at cycle 12.
REQ-041 req=2'b11 held continuously -> grants alternate 0,1,0,1; a new gnt occurs every rel+3 cycles.
REQ-042 Owner 1 writes addr 0x1ABC, data 0x5A5A with wren in the rel cycle and the next cycle -> both writes appear on fb_*; fb_wren=0 afterwards.
REQ-043 MAX_HOLD=16, owner never releases -> GAP at the 16th BUSY cycle, err_timeout=1 and sticky, other requester granted next.
REQ-044 rel[1] pulsed while owner=0, and rel during GRANT -> both ignored; ownership continues until rel[0].
REQ-045 rst_n low mid-BUSY with wren=1 -> fb_wren=0 and gnt=0 immediately; after reset, req=2'b11 -> requester 0 granted first.
